// File: rtl/pc_next_unit_pkg.sv
// Shared definitions for the PC unit and the control unit.
// Holds the next-PC source encodings and the word-alignment helper.
package pc_next_unit_pkg;

    localparam int PC_SEL_W = 3;

    // Next-PC source select encodings, shared with the control unit.
    typedef enum logic [PC_SEL_W-1:0] {
        PCSRC_SEQ  = 3'b000,
        PCSRC_JUMP = 3'b001,
        PCSRC_SYSC = 3'b010,
        PCSRC_XREG = 3'b011,
        PCSRC_ZREG = 3'b100,
        PCSRC_ALU  = 3'b101,
        PCSRC_EPC  = 3'b110,
        PCSRC_RAS  = 3'b111
    } pc_src_sel_e;

    // Clear the two byte-offset bits of a 32-bit address.
    function automatic logic [31:0] word_align32(input logic [31:0] a);
        return {a[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/pc_next_unit_ras.sv
// Return-address stack: circular storage, pointer and occupancy count.
// Ports: push/pop (already qualified), wdata in; top, empty, full out.
module pc_next_unit_ras #(
    parameter int XLEN      = 32,
    parameter int RAS_DEPTH = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            push,
    input  logic            pop,
    input  logic [XLEN-1:0] wdata,
    output logic [XLEN-1:0] top,
    output logic            empty,
    output logic            full
);

    localparam int PW = $clog2(RAS_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(RAS_DEPTH);

    logic [XLEN-1:0] entry [RAS_DEPTH];
    logic [PW-1:0]   ptr;
    logic [CW-1:0]   count;
    logic [PW-1:0]   top_idx;

    assign top_idx = ptr - 1'b1;
    assign empty   = (count == '0);
    assign full    = (count == DEPTH_C);
    assign top     = empty ? '0 : entry[top_idx];

    // Push+pop on a non-empty stack replaces the top in place.
    logic do_replace;
    logic do_push;
    logic do_pop;

    assign do_replace = push && pop && !empty;
    assign do_push    = push && !do_replace;
    assign do_pop     = pop && !push && !empty;

    always_ff @(posedge clk) begin
        if (!reset) begin
            ptr   <= '0;
            count <= '0;
        end else if (do_push) begin
            ptr <= ptr + 1'b1;
            if (!full)
                count <= count + 1'b1;
        end else if (do_pop) begin
            ptr   <= ptr - 1'b1;
            count <= count - 1'b1;
        end
    end

    // Storage is deliberately left uncleared by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            if (do_push)
                entry[ptr] <= wdata;
            else if (do_replace)
                entry[top_idx] <= wdata;
        end
    end

endmodule

// File: rtl/pc_next_unit.sv
// PC register, next-PC 8:1 select, Z capture, EPC and return-address stack.
// Ports: control selects/enables and operands in; pc, pc_src, RAS status out.
module pc_next_unit
    import pc_next_unit_pkg::*;
#(
    parameter int              XLEN         = 32,
    parameter int              JTA_W        = 26,
    parameter int              RAS_DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_VECTOR = 32'h1000_0000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              pc_write,
    input  logic [2:0]        pc_src_sel,
    input  logic [XLEN-1:0]   alu_out,
    input  logic [XLEN-1:0]   x_reg_out,
    input  logic [JTA_W-1:0]  jta,
    input  logic [XLEN-3:0]   syscall,
    input  logic              epc_write,
    input  logic              ras_push,
    input  logic              ras_pop,
    output logic [XLEN-1:0]   pc,
    output logic [XLEN-1:0]   pc_plus4,
    output logic [XLEN-1:0]   pc_src,
    output logic [XLEN-1:0]   z_reg_out,
    output logic [XLEN-1:0]   epc,
    output logic [XLEN-1:0]   ras_top,
    output logic              ras_empty,
    output logic              ras_full
);

    assign pc_plus4 = pc + XLEN'(4);

    always_comb begin
        pc_src = pc_plus4;
        unique case (pc_src_sel_e'(pc_src_sel))
            PCSRC_SEQ:  pc_src = pc_plus4;
            PCSRC_JUMP: pc_src = {pc_plus4[XLEN-1:JTA_W+2], jta, 2'b00};
            PCSRC_SYSC: pc_src = {syscall, 2'b00};
            PCSRC_XREG: pc_src = x_reg_out;
            PCSRC_ZREG: pc_src = z_reg_out;
            PCSRC_ALU:  pc_src = alu_out;
            PCSRC_EPC:  pc_src = epc;
            PCSRC_RAS:  pc_src = ras_empty ? pc_plus4 : ras_top;
            default:    pc_src = pc_plus4;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            pc        <= RESET_VECTOR;
            z_reg_out <= '0;
            epc       <= '0;
        end else begin
            z_reg_out <= alu_out;
            if (pc_write)
                pc <= {pc_src[XLEN-1:2], 2'b00};
            if (epc_write)
                epc <= pc;
        end
    end

    // RAS only moves on committed PC updates so stalls hold it.
    pc_next_unit_ras #(
        .XLEN      (XLEN),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk   (clk),
        .reset (reset),
        .push  (ras_push && pc_write),
        .pop   (ras_pop && pc_write),
        .wdata (pc_plus4),
        .top   (ras_top),
        .empty (ras_empty),
        .full  (ras_full)
    );

endmodule

// File: tb/tb_pc_next_unit.sv
// Directed self-checking bench for pc_next_unit.
// Each task drives one scenario and checks against hand-computed values.
module tb_pc_next_unit;

    logic        clk;
    logic        reset;
    logic        pc_write;
    logic [2:0]  pc_src_sel;
    logic [31:0] alu_out;
    logic [31:0] x_reg_out;
    logic [25:0] jta;
    logic [29:0] syscall;
    logic        epc_write;
    logic        ras_push;
    logic        ras_pop;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] pc_src;
    logic [31:0] z_reg_out;
    logic [31:0] epc;
    logic [31:0] ras_top;
    logic        ras_empty;
    logic        ras_full;

    int vectors = 0;
    int errors  = 0;

    pc_next_unit dut (
        .clk        (clk),
        .reset      (reset),
        .pc_write   (pc_write),
        .pc_src_sel (pc_src_sel),
        .alu_out    (alu_out),
        .x_reg_out  (x_reg_out),
        .jta        (jta),
        .syscall    (syscall),
        .epc_write  (epc_write),
        .ras_push   (ras_push),
        .ras_pop    (ras_pop),
        .pc         (pc),
        .pc_plus4   (pc_plus4),
        .pc_src     (pc_src),
        .z_reg_out  (z_reg_out),
        .epc        (epc),
        .ras_top    (ras_top),
        .ras_empty  (ras_empty),
        .ras_full   (ras_full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change on the falling edge; outputs are sampled there too.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        pc_write   = 1'b0;
        pc_src_sel = 3'b000;
        epc_write  = 1'b0;
        ras_push   = 1'b0;
        ras_pop    = 1'b0;
    endtask

    task automatic set_pc(input logic [31:0] v);
        idle();
        pc_src_sel = 3'b011;
        x_reg_out  = v;
        pc_write   = 1'b1;
        step();
        idle();
    endtask

    task automatic test_reset();
        idle();
        alu_out   = 32'h5555_5555;
        x_reg_out = '0;
        jta       = '0;
        syscall   = '0;
        reset     = 1'b0;
        step();
        step();
        vectors++;
        if (pc !== 32'h1000_0000) begin
            errors++;
            $display("FAIL reset_pc got %h want %h", pc, 32'h1000_0000);
        end
        vectors++;
        if (z_reg_out !== 32'h0) begin
            errors++;
            $display("FAIL reset_z got %h want 0", z_reg_out);
        end
        vectors++;
        if (epc !== 32'h0) begin
            errors++;
            $display("FAIL reset_epc got %h want 0", epc);
        end
        vectors++;
        if (ras_empty !== 1'b1 || ras_top !== 32'h0) begin
            errors++;
            $display("FAIL reset_ras got empty=%b top=%h want 1/0",
                     ras_empty, ras_top);
        end
        reset = 1'b1;
    endtask

    task automatic test_jump();
        idle();
        pc_src_sel = 3'b001;
        jta        = 26'h3FF_FFFF;
        pc_write   = 1'b1;
        #1;
        vectors++;
        if (pc_src !== 32'h1FFF_FFFC) begin
            errors++;
            $display("FAIL jump_src got %h want %h", pc_src, 32'h1FFF_FFFC);
        end
        step();
        vectors++;
        if (pc !== 32'h1FFF_FFFC) begin
            errors++;
            $display("FAIL jump_pc got %h want %h", pc, 32'h1FFF_FFFC);
        end
        idle();
    endtask

    task automatic test_syscall_epc();
        set_pc(32'h1000_0010);
        pc_src_sel = 3'b010;
        syscall    = 30'h3FFF_FFFF;
        pc_write   = 1'b1;
        epc_write  = 1'b1;
        step();
        vectors++;
        if (pc !== 32'hFFFF_FFFC) begin
            errors++;
            $display("FAIL sysc_pc got %h want %h", pc, 32'hFFFF_FFFC);
        end
        vectors++;
        if (epc !== 32'h1000_0010) begin
            errors++;
            $display("FAIL sysc_epc got %h want %h", epc, 32'h1000_0010);
        end
        // pc_plus4 wraps from the top of the address space.
        vectors++;
        if (pc_plus4 !== 32'h0000_0000) begin
            errors++;
            $display("FAIL plus4_wrap got %h want 0", pc_plus4);
        end
        idle();
        pc_src_sel = 3'b110;
        pc_write   = 1'b1;
        step();
        vectors++;
        if (pc !== 32'h1000_0010) begin
            errors++;
            $display("FAIL eret_pc got %h want %h", pc, 32'h1000_0010);
        end
        idle();
    endtask

    task automatic test_z_alu_x();
        idle();
        alu_out = 32'hDEAD_BEEF;
        step();
        alu_out = 32'hCAFE_BABE;
        vectors++;
        if (z_reg_out !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL z_delay got %h want %h", z_reg_out, 32'hDEAD_BEEF);
        end
        pc_src_sel = 3'b100;
        #1;
        vectors++;
        if (pc_src !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL z_src got %h want %h", pc_src, 32'hDEAD_BEEF);
        end
        pc_src_sel = 3'b101;
        pc_write   = 1'b1;
        #1;
        vectors++;
        if (pc_src !== 32'hCAFE_BABE) begin
            errors++;
            $display("FAIL alu_src got %h want %h", pc_src, 32'hCAFE_BABE);
        end
        step();
        vectors++;
        if (pc !== 32'hCAFE_BABC) begin
            errors++;
            $display("FAIL alu_pc got %h want %h", pc, 32'hCAFE_BABC);
        end
        pc_src_sel = 3'b011;
        x_reg_out  = 32'h1234_5678;
        #1;
        vectors++;
        if (pc_src !== 32'h1234_5678) begin
            errors++;
            $display("FAIL x_src got %h want %h", pc_src, 32'h1234_5678);
        end
        step();
        vectors++;
        if (pc !== 32'h1234_5678) begin
            errors++;
            $display("FAIL x_pc got %h want %h", pc, 32'h1234_5678);
        end
        idle();
    endtask

    task automatic test_ras_wrap();
        logic [31:0] exp_pop [4];
        exp_pop[0] = 32'h504;
        exp_pop[1] = 32'h404;
        exp_pop[2] = 32'h304;
        exp_pop[3] = 32'h204;
        set_pc(32'h100);
        for (int i = 1; i <= 5; i++) begin
            pc_src_sel = 3'b011;
            x_reg_out  = 32'((i + 1) * 'h100);
            pc_write   = 1'b1;
            ras_push   = 1'b1;
            step();
        end
        idle();
        vectors++;
        if (ras_full !== 1'b1 || pc !== 32'h600) begin
            errors++;
            $display("FAIL ras_full got full=%b pc=%h want 1/600",
                     ras_full, pc);
        end
        for (int i = 0; i < 4; i++) begin
            pc_src_sel = 3'b111;
            pc_write   = 1'b1;
            ras_pop    = 1'b1;
            #1;
            vectors++;
            if (pc_src !== exp_pop[i]) begin
                errors++;
                $display("FAIL ras_pop%0d got %h want %h",
                         i, pc_src, exp_pop[i]);
            end
            step();
        end
        vectors++;
        if (ras_empty !== 1'b1 || ras_top !== 32'h0 || pc !== 32'h204) begin
            errors++;
            $display("FAIL ras_drain got empty=%b top=%h pc=%h want 1/0/204",
                     ras_empty, ras_top, pc);
        end
        // Pop on empty is a no-op; sel 111 falls back to pc_plus4.
        #1;
        vectors++;
        if (pc_src !== 32'h208) begin
            errors++;
            $display("FAIL ras_empty_src got %h want 208", pc_src);
        end
        step();
        vectors++;
        if (ras_empty !== 1'b1 || ras_full !== 1'b0 || pc !== 32'h208) begin
            errors++;
            $display("FAIL ras_pop_empty got empty=%b full=%b pc=%h want 1/0/208",
                     ras_empty, ras_full, pc);
        end
        idle();
    endtask

    task automatic test_stall_simul();
        set_pc(32'h200);
        ras_push = 1'b1;
        step();
        vectors++;
        if (ras_empty !== 1'b1 || pc !== 32'h200) begin
            errors++;
            $display("FAIL stall_push got empty=%b pc=%h want 1/200",
                     ras_empty, pc);
        end
        pc_src_sel = 3'b011;
        x_reg_out  = 32'h600;
        pc_write   = 1'b1;
        step();
        vectors++;
        if (ras_top !== 32'h204 || pc !== 32'h600) begin
            errors++;
            $display("FAIL push_one got top=%h pc=%h want 204/600", ras_top, pc);
        end
        x_reg_out = 32'h700;
        ras_pop   = 1'b1;
        step();
        vectors++;
        if (ras_top !== 32'h604 || ras_empty !== 1'b0 || ras_full !== 1'b0) begin
            errors++;
            $display("FAIL push_pop got top=%h empty=%b full=%b want 604/0/0",
                     ras_top, ras_empty, ras_full);
        end
        // A single pop must now drain it: count stayed at one.
        ras_push   = 1'b0;
        pc_src_sel = 3'b111;
        step();
        vectors++;
        if (ras_empty !== 1'b1 || pc !== 32'h604) begin
            errors++;
            $display("FAIL push_pop_count got empty=%b pc=%h want 1/604",
                     ras_empty, pc);
        end
        idle();
        pc_src_sel = 3'b011;
        x_reg_out  = 32'h800;
        pc_write   = 1'b1;
        ras_push   = 1'b1;
        epc_write  = 1'b1;
        alu_out    = 32'h1111_2222;
        step();
        reset = 1'b0;
        step();
        reset = 1'b1;
        idle();
        vectors++;
        if (pc !== 32'h1000_0000 || epc !== 32'h0 || z_reg_out !== 32'h0) begin
            errors++;
            $display("FAIL mid_reset got pc=%h epc=%h z=%h want 10000000/0/0",
                     pc, epc, z_reg_out);
        end
        vectors++;
        if (ras_empty !== 1'b1 || ras_top !== 32'h0) begin
            errors++;
            $display("FAIL mid_reset_ras got empty=%b top=%h want 1/0",
                     ras_empty, ras_top);
        end
    endtask

    initial begin
        reset = 1'b0;
        idle();
        @(negedge clk);
        test_reset();
        test_jump();
        test_syscall_epc();
        test_z_alu_x();
        test_ras_wrap();
        test_stall_simul();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
